// File: rtl/res_st_dispatch.sv
// Issue-side consumer of the reservation station: round-robin picks a ready entry,
// hands it to a functional unit over valid/ready, then frees the slot.

package res_st_pkg;
  localparam int RES_ST_DEPTH_DEF = 32;
  localparam int RES_ST_AW        = $clog2(RES_ST_DEPTH_DEF);
  localparam int OP_W             = 13;
  localparam int DATA_W           = 32;

  typedef logic [RES_ST_AW-1:0] res_st_addr_t;

  typedef struct packed {
    logic              busy;
    res_st_addr_t      qj;
    res_st_addr_t      qk;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [DATA_W-1:0] a;
  } res_st_cell_t;
endpackage

module res_st_dispatch
  import res_st_pkg::*;
#(
  parameter int RES_ST_DEPTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            flush,
  output logic [$clog2(RES_ST_DEPTH)-1:0] rd_addr,
  input  res_st_cell_t                    rd_in,
  output logic                            fu_valid,
  input  logic                            fu_ready,
  output logic [OP_W-1:0]                 fu_op,
  output logic [DATA_W-1:0]               fu_vj,
  output logic [DATA_W-1:0]               fu_vk,
  output logic [DATA_W-1:0]               fu_a,
  output logic [$clog2(RES_ST_DEPTH)-1:0] fu_tag,
  output logic                            retire_en,
  output logic [$clog2(RES_ST_DEPTH)-1:0] retire_addr
);

  localparam int AW = $clog2(RES_ST_DEPTH);

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    ISSUE  = 2'd1,
    RETIRE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [AW-1:0]       ptr_r;
  logic [AW-1:0]       ptr_s;
  logic                ready_s;
  logic                fu_valid_s;
  logic [OP_W-1:0]     fu_op_s;
  logic [DATA_W-1:0]   fu_vj_s;
  logic [DATA_W-1:0]   fu_vk_s;
  logic [DATA_W-1:0]   fu_a_s;
  logic [AW-1:0]       fu_tag_s;
  logic                retire_en_s;
  logic [AW-1:0]       retire_addr_s;

  // A zero producer tag means the operand value is already present.
  assign ready_s = rd_in.busy
                   && (rd_in.qj == {RES_ST_AW{1'b0}})
                   && (rd_in.qk == {RES_ST_AW{1'b0}});

  assign rd_addr = ptr_r;

  // Next-state and next-output logic; flush overrides every transition.
  always_comb begin
    state_s       = state_r;
    ptr_s         = ptr_r;
    fu_valid_s    = fu_valid;
    fu_op_s       = fu_op;
    fu_vj_s       = fu_vj;
    fu_vk_s       = fu_vk;
    fu_a_s        = fu_a;
    fu_tag_s      = fu_tag;
    retire_en_s   = 1'b0;
    retire_addr_s = retire_addr;
    if (flush) begin
      state_s    = SCAN;
      fu_valid_s = 1'b0;
    end else begin
      case (state_r)
        SCAN: begin
          if (en) begin
            if (ready_s) begin
              fu_op_s    = rd_in.op;
              fu_vj_s    = rd_in.vj;
              fu_vk_s    = rd_in.vk;
              fu_a_s     = rd_in.a;
              fu_tag_s   = ptr_r;
              fu_valid_s = 1'b1;
              state_s    = ISSUE;
            end else begin
              ptr_s = ptr_r + AW'(1'b1);
            end
          end else begin
            ptr_s = ptr_r;
          end
        end
        ISSUE: begin
          if (fu_ready) begin
            fu_valid_s    = 1'b0;
            retire_en_s   = 1'b1;
            retire_addr_s = fu_tag;
            state_s       = RETIRE;
          end else begin
            fu_valid_s = 1'b1;
          end
        end
        RETIRE: begin
          // Resume just past the freed slot so it is examined last.
          ptr_s   = fu_tag + AW'(1'b1);
          state_s = SCAN;
        end
        default: begin
          state_s    = SCAN;
          fu_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= SCAN;
      ptr_r       <= {AW{1'b0}};
      fu_valid    <= 1'b0;
      fu_op       <= {OP_W{1'b0}};
      fu_vj       <= {DATA_W{1'b0}};
      fu_vk       <= {DATA_W{1'b0}};
      fu_a        <= {DATA_W{1'b0}};
      fu_tag      <= {AW{1'b0}};
      retire_en   <= 1'b0;
      retire_addr <= {AW{1'b0}};
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      fu_valid    <= fu_valid_s;
      fu_op       <= fu_op_s;
      fu_vj       <= fu_vj_s;
      fu_vk       <= fu_vk_s;
      fu_a        <= fu_a_s;
      fu_tag      <= fu_tag_s;
      retire_en   <= retire_en_s;
      retire_addr <= retire_addr_s;
    end
  end

endmodule

// File: tb/tb_res_st_dispatch.sv
// Self-checking bench for res_st_dispatch: directed table, corner sequences and
// randomized station contents checked against a round-robin search model.

module tb_res_st_dispatch;
  import res_st_pkg::*;

  localparam int N = 32;

  logic              clk;
  logic              rst;
  logic              en;
  logic              flush;
  logic [4:0]        rd_addr;
  res_st_cell_t      rd_in;
  logic              fu_valid;
  logic              fu_ready;
  logic [12:0]       fu_op;
  logic [31:0]       fu_vj;
  logic [31:0]       fu_vk;
  logic [31:0]       fu_a;
  logic [4:0]        fu_tag;
  logic              retire_en;
  logic [4:0]        retire_addr;

  res_st_cell_t station [N];
  int n_cmp;
  int n_fail;
  int mptr;

  res_st_dispatch #(.RES_ST_DEPTH(N)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .rd_addr(rd_addr), .rd_in(rd_in),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_op(fu_op), .fu_vj(fu_vj), .fu_vk(fu_vk), .fu_a(fu_a), .fu_tag(fu_tag),
    .retire_en(retire_en), .retire_addr(retire_addr)
  );

  assign rd_in = station[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic rdy;
    logic fl;
    int   e_addr;
    logic e_valid;
    logic e_ret;
    int   e_tag;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: the station frees a slot when it sees retire_en at the edge.
  task automatic tick();
    logic       seen;
    logic [4:0] a;
    @(posedge clk);
    seen = retire_en;
    a    = retire_addr;
    #1;
    if (seen) station[a].busy = 1'b0;
    @(negedge clk);
  endtask

  function automatic int first_ready(input int from);
    for (int d = 0; d < N; d++) begin
      int idx;
      idx = (from + d) % N;
      if (station[idx].busy && station[idx].qj == 5'd0 && station[idx].qk == 5'd0)
        return d;
    end
    return -1;
  endfunction

  function automatic res_st_cell_t mk_cell(input logic b, input logic [4:0] qj, input logic [4:0] qk);
    res_st_cell_t c;
    c.busy = b;
    c.qj   = qj;
    c.qk   = qk;
    c.op   = 13'($urandom);
    c.vj   = $urandom;
    c.vk   = $urandom;
    c.a    = $urandom;
    return c;
  endfunction

  // Scan with no ready entry: pointer advances one slot per cycle.
  task automatic scan_idle(input int k);
    en    = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < k; i++) begin
      chk("idle_rd_addr", 64'(rd_addr), 64'(mptr));
      chk("idle_fu_valid", 64'(fu_valid), 64'd0);
      chk("idle_retire_en", 64'(retire_en), 64'd0);
      tick();
      mptr = (mptr + 1) % N;
    end
  endtask

  // Expect the next round-robin dispatch from mptr, hold it, then see its retire.
  task automatic dispatch_one(input int hold);
    int           d;
    int           lat;
    logic [4:0]   t;
    res_st_cell_t c;
    d = first_ready(mptr);
    if (d < 0) return;
    t = 5'((mptr + d) % N);
    c = station[t];
    en       = 1'b1;
    flush    = 1'b0;
    fu_ready = (hold == 0);
    lat = 0;
    while (!fu_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("dispatch_latency", 64'(lat), 64'(d + 1));
    chk("fu_tag", 64'(fu_tag), 64'(t));
    chk("fu_op", 64'(fu_op), 64'(c.op));
    chk("fu_vj", 64'(fu_vj), 64'(c.vj));
    chk("fu_vk", 64'(fu_vk), 64'(c.vk));
    chk("fu_a", 64'(fu_a), 64'(c.a));
    station[t].vj = ~c.vj;
    station[t].op = ~c.op;
    for (int i = 0; i < hold; i++) begin
      chk("hold_fu_valid", 64'(fu_valid), 64'd1);
      chk("hold_payload", 64'({fu_tag, fu_op, fu_vj}), 64'({t, c.op, c.vj}));
      chk("hold_retire_en", 64'(retire_en), 64'd0);
      tick();
    end
    fu_ready = 1'b1;
    tick();
    chk("hs_fu_valid", 64'(fu_valid), 64'd0);
    chk("hs_retire_en", 64'(retire_en), 64'd1);
    chk("hs_retire_addr", 64'(retire_addr), 64'(t));
    fu_ready = 1'b0;
    tick();
    chk("retire_pulse_len", 64'(retire_en), 64'd0);
    mptr = (t + 1) % N;
    chk("rd_addr_after_retire", 64'(rd_addr), 64'(mptr));
  endtask

  vec_t tbl [7];

  initial begin
    int w;
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b0;
    en       = 1'b0;
    flush    = 1'b0;
    fu_ready = 1'b0;
    for (int i = 0; i < N; i++) station[i] = '0;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 2};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b1, 2};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 0};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_fu_valid", 64'(fu_valid), 64'd0);
    chk("rst_retire_en", 64'(retire_en), 64'd0);
    chk("rst_retire_addr", 64'(retire_addr), 64'd0);
    chk("rst_payload", 64'({fu_op, fu_tag, fu_vj}), 64'd0);
    chk("rst_payload2", 64'({fu_vk, fu_a}), 64'd0);
    rst  = 1'b1;
    mptr = 0;

    // Empty station: pointer walks 0..31,0..7
    scan_idle(40);
    chk("empty_final_rd_addr", 64'(rd_addr), 64'd8);

    // Directed table from a fresh reset, entry 2 ready
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    station[2]    = '0;
    station[2].busy = 1'b1;
    station[2].op = 13'h0F0F;
    station[2].vj = 32'd10;
    station[2].vk = 32'd5;
    for (int i = 0; i < 7; i++) begin
      chk("tbl_rd_addr", 64'(rd_addr), 64'(tbl[i].e_addr));
      chk("tbl_fu_valid", 64'(fu_valid), 64'(tbl[i].e_valid));
      chk("tbl_retire_en", 64'(retire_en), 64'(tbl[i].e_ret));
      if (tbl[i].e_valid) begin
        chk("tbl_fu_tag", 64'(fu_tag), 64'(tbl[i].e_tag));
        chk("tbl_fu_payload", 64'({fu_op, fu_vj, fu_vk}), {13'h0F0F, 32'd10, 32'd5} & 64'hFFFF_FFFF_FFFF_FFFF);
        chk("tbl_fu_vj", 64'(fu_vj), 64'd10);
      end
      if (tbl[i].e_ret) chk("tbl_retire_addr", 64'(retire_addr), 64'(tbl[i].e_tag));
      en       = tbl[i].en;
      fu_ready = tbl[i].rdy;
      flush    = tbl[i].fl;
      tick();
    end
    fu_ready = 1'b0;
    mptr = 4;

    // Entry 3 blocked on qj, released while the pointer is elsewhere
    station[3] = mk_cell(1'b1, 5'd4, 5'd0);
    scan_idle(34);
    station[3].qj = 5'd0;
    dispatch_one(0);

    // Entries 5 and 6 ready, functional unit stalls for 4 cycles
    station[5] = mk_cell(1'b1, 5'd0, 5'd0);
    station[6] = mk_cell(1'b1, 5'd0, 5'd0);
    dispatch_one(4);
    dispatch_one(0);

    // Flush during ISSUE discards the handshake
    station[7] = mk_cell(1'b1, 5'd0, 5'd0);
    fu_ready = 1'b0;
    w = 0;
    while (!fu_valid && w < 40) begin tick(); w++; end
    chk("flush_pre_valid", 64'(fu_valid), 64'd1);
    chk("flush_pre_tag", 64'(fu_tag), 64'd7);
    flush    = 1'b1;
    fu_ready = 1'b1;
    tick();
    flush    = 1'b0;
    fu_ready = 1'b0;
    en       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("flush_fu_valid", 64'(fu_valid), 64'd0);
      chk("flush_retire_en", 64'(retire_en), 64'd0);
      chk("flush_rd_addr", 64'(rd_addr), 64'd7);
      tick();
    end
    mptr = 7;
    dispatch_one(0);

    // Wrap through entry 31
    station[31] = mk_cell(1'b1, 5'd0, 5'd0);
    dispatch_one(1);

    // Reset asserted mid-RETIRE
    station[9] = mk_cell(1'b1, 5'd0, 5'd0);
    fu_ready = 1'b1;
    w = 0;
    while (!fu_valid && w < 40) begin tick(); w++; end
    chk("rstmid_tag", 64'(fu_tag), 64'd9);
    tick();
    chk("rstmid_retire_en_pre", 64'(retire_en), 64'd1);
    rst = 1'b0;
    #1;
    chk("rstmid_retire_en", 64'(retire_en), 64'd0);
    chk("rstmid_fu_valid", 64'(fu_valid), 64'd0);
    chk("rstmid_rd_addr", 64'(rd_addr), 64'd0);
    @(negedge clk);
    rst      = 1'b1;
    fu_ready = 1'b0;
    mptr     = 0;
    dispatch_one(0);

    // Randomized station contents, enable gaps and flushes
    for (int r = 0; r < 60; r++) begin
      int sel;
      sel = $urandom_range(0, 4);
      if (sel <= 2) begin
        int nw;
        nw = $urandom_range(1, 3);
        for (int k = 0; k < nw; k++) begin
          int idx;
          idx = $urandom_range(0, N - 1);
          station[idx] = mk_cell(1'($urandom_range(0, 3) != 0),
                                 ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                                 ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0);
        end
        if (first_ready(mptr) >= 0) dispatch_one($urandom_range(0, 3));
        else scan_idle($urandom_range(1, 5));
      end else if (sel == 3) begin
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
          chk("gap_rd_addr", 64'(rd_addr), 64'(mptr));
          chk("gap_fu_valid", 64'(fu_valid), 64'd0);
          tick();
        end
        en = 1'b1;
      end else begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("scanflush_rd_addr", 64'(rd_addr), 64'(mptr));
        chk("scanflush_fu_valid", 64'(fu_valid), 64'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/res_st_dispatch.md
Name: res_st_dispatch

Overview:
- Consumer side of the reservation station.
- Round-robin scans the station through one read port and selects an entry that is busy with both operand tags cleared.
- Latches that entry's payload and presents it to a functional unit over a valid/ready handshake.
- Once the handshake completes, frees the slot through the station's retire port.
- Sits between res_st and the execution units; one instance per read port used for issue.

Parameters:
- RES_ST_DEPTH, 32, number of station entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  scan enable; while 0, SCAN holds ptr and selects nothing.
- flush  in  1  synchronous abort: return to SCAN, drop fu_valid, no retire.
- rd_addr  out  $clog2(RES_ST_DEPTH)  station read address (drive to res_st rdN_addr).
- rd_in  in  res_st_cell_t  station read data; combinational, same-cycle w.r.t. rd_addr.
- fu_valid  out  1  dispatched uop valid.
- fu_ready  in  1  functional unit accepts.
- fu_op  out  width of res_st_cell_t.op  latched op.
- fu_vj  out  width of .vj  latched operand j.
- fu_vk  out  width of .vk  latched operand k.
- fu_a  out  width of .a  latched immediate/address.
- fu_tag  out  res_st_addr_t  station index of the dispatched entry.
- retire_en  out  1  one-cycle pulse freeing retire_addr.
- retire_addr  out  res_st_addr_t  slot being freed.

Behaviour:
- Reset (rst=0, async):
  - state=SCAN, ptr=0, rd_addr=0.
  - fu_valid=0, fu_op/vj/vk/a/tag=0.
  - retire_en=0, retire_addr=0.
- rd_addr = ptr in all states; it is only sampled in SCAN.
- Ready condition: rd_in.busy==1 && rd_in.qj==0 && rd_in.qk==0. Tag 0 means the operand value is present.
- SCAN, en=1, ready condition true:
  - Register op/vj/vk/a, tag=ptr.
  - Next cycle: fu_valid=1, state=ISSUE.
- SCAN, en=1, not ready: ptr=ptr+1, wrapping DEPTH-1 to 0. One entry is examined per cycle.
- SCAN, en=0: ptr holds and nothing is selected.
- ISSUE:
  - fu_valid=1 and payload stable until fu_valid&&fu_ready.
  - fu_ready may arrive in the same cycle fu_valid first rises; the handshake then completes that cycle.
  - en is ignored.
- Handshake cycle:
  - Next cycle: fu_valid=0, retire_en=1, retire_addr=fu_tag, state=RETIRE.
- RETIRE:
  - Lasts exactly one cycle with retire_en=1.
  - Then retire_en=0, ptr=fu_tag+1 (wrapped), state=SCAN.
  - The slot just freed is examined last, giving fairness.
- Latency:
  - Ready entry at ptr in SCAN to fu_valid: 1 cycle.
  - Handshake to retire_en: 1 cycle.
  - Minimum SCAN→SCAN period: 3 cycles.
  - Worst-case search: RES_ST_DEPTH cycles.
- Empty station: ptr cycles indefinitely; no outputs toggle other than rd_addr.
- Entry modified by the writer after selection: no effect; the payload is already latched.
- flush:
  - From any state, next cycle: state=SCAN, fu_valid=0, retire_en=0; ptr unchanged.
  - A handshake in the same cycle as flush is discarded, with no retire.
  - flush has priority over all transitions.
- Reset mid-ISSUE/RETIRE: outputs clear immediately (async); no retire is issued.
- Exactly one uop in flight; never two retire pulses per dispatch.

Test Plan:
1. Reset, en=1, station empty (all busy=0) for 40 cycles:
   - fu_valid and retire_en stay 0.
   - rd_addr walks 0..31,0..7.
2. Entry 2 = {busy=1, qj=0, qk=0, op=13'h0F0F, vj=10, vk=5, a=0}, fu_ready=1:
   - fu_valid=1 with fu_tag=2, fu_vj=10, fu_vk=5, fu_op=13'h0F0F one cycle after rd_addr=2.
   - retire_en=1, retire_addr=2 the next cycle.
   - rd_addr=3 after that.
3. Entry 3 = {busy=1, qj=4, qk=0}: never dispatched. Rewrite qj=0 while ptr is elsewhere:
   - Dispatched on the next visit to 3.
4. Entries 5 and 6 ready, fu_ready=0 for 4 cycles then 1:
   - fu_valid held 4+ cycles with tag=5 and stable payload.
   - Then retire 5, then dispatch 6, then retire 6.
5. Entry 31 ready, ptr reaches 31:
   - Dispatch tag=31, retire_addr=31.
   - ptr wraps to 0.
6. flush during ISSUE (tag=7):
   - fu_valid drops next cycle and no retire_en pulse occurs.
   - Entry 7 is redispatched on a later scan.
   - Separately, rst=0 asserted mid-RETIRE clears retire_en asynchronously.
